// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - I2C bus pins shared by a bus master (or bus model) and the target
//
// Signals:
//   scl_in  : bus SCL level seen by the target (asynchronous to the target clock)
//   sda_in  : bus SDA level seen by the target (asynchronous to the target clock)
//   sda_out : target SDA drive, 1 = release (open drain high), 0 = pull low
// Modports:
//   master : drives scl_in/sda_in, observes sda_out
//   slave  : the target side, observes scl_in/sda_in, drives sda_out

interface i2c_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_out;

  modport master (output scl_in, output sda_in, input sda_out);
  modport slave  (input scl_in, input sda_in, output sda_out);
endinterface

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with a small byte register file and a local load port
//
// Build option: define I2C_TARGET_AUTOINC_EN to advance the register pointer after
// every data byte written or read; otherwise the pointer holds the value loaded
// by the pointer byte.
//
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : i2c_target_if.slave (scl_in, sda_in asynchronous; sda_out 1 = release)
//   ld_we    : local register load strobe, ld_addr/ld_data give index and value
//   rx_valid : one-cycle pulse per byte written by the bus master
//   rx_addr  : register index of the last bus write
//   rx_data  : value of the last bus write
//   busy     : high while this target is addressed

module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h52,
  parameter int         NUM_REGS = 8,
  localparam int        PW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  i2c_target_if.slave   bus,
  input  logic          ld_we,
  input  logic [PW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          rx_valid,
  output logic [PW-1:0] rx_addr,
  output logic [7:0]    rx_data,
  output logic          busy
);

`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_MISMATCH
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_scl_s1, r_scl_s2, r_scl_d;
  logic          r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_rw;
  logic [PW-1:0] r_ptr;
  logic [7:0]    r_regs [NUM_REGS];
  logic          r_sda_out;
  logic          r_rx_valid;
  logic [PW-1:0] r_rx_addr;
  logic [7:0]    r_rx_data;
  logic          w_busy;
  logic          w_ack_state;
  logic          w_byte_state;

  wire w_scl_rise = r_scl_s2 & ~r_scl_d;
  wire w_scl_fall = ~r_scl_s2 & r_scl_d;
  wire w_start    = r_scl_s2 & r_sda_d & ~r_sda_s2;
  wire w_stop     = r_scl_s2 & ~r_sda_d & r_sda_s2;
  wire w_last_bit = (r_bitcnt == 3'd7);
  wire [7:0] w_byte = {r_shift[6:0], r_sda_s2};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; START/STOP override every state
  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = S_ADDR;
    end else if (w_stop) begin
      w_state_next = S_IDLE;
    end else if (w_scl_rise) begin
      case (r_state)
        S_ADDR:      if (w_last_bit) w_state_next = (w_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_MISMATCH;
        S_ADDR_ACK:  w_state_next = r_rw ? S_RDATA : S_PTR;
        S_PTR:       if (w_last_bit) w_state_next = S_PTR_ACK;
        S_PTR_ACK:   w_state_next = S_WDATA;
        S_WDATA:     if (w_last_bit) w_state_next = S_WDATA_ACK;
        S_WDATA_ACK: w_state_next = S_WDATA;
        S_RDATA:     if (w_last_bit) w_state_next = S_RDATA_ACK;
        S_RDATA_ACK: w_state_next = r_sda_s2 ? S_MISMATCH : S_RDATA;
        default:     w_state_next = r_state;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    w_busy       = (r_state != S_IDLE) && (r_state != S_MISMATCH);
    w_ack_state  = (r_state == S_ADDR_ACK) || (r_state == S_PTR_ACK) || (r_state == S_WDATA_ACK);
    w_byte_state = (r_state == S_ADDR) || (r_state == S_PTR) || (r_state == S_WDATA);
  end

  // Synchronizers, bit/byte datapath, register file and SDA drive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_d    <= 1'b1;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_ptr      <= '0;
      r_sda_out  <= 1'b1;
      r_rx_valid <= 1'b0;
      r_rx_addr  <= '0;
      r_rx_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_scl_s1   <= bus.scl_in;
      r_scl_s2   <= r_scl_s1;
      r_scl_d    <= r_scl_s2;
      r_sda_s1   <= bus.sda_in;
      r_sda_s2   <= r_sda_s1;
      r_sda_d    <= r_sda_s2;
      r_rx_valid <= 1'b0;

      // Local load first so a same-cycle bus write to the same index overrides it
      if (ld_we) r_regs[ld_addr] <= ld_data;

      if (w_start || w_stop) begin
        r_bitcnt  <= '0;
        r_sda_out <= 1'b1;
      end else if (w_scl_rise) begin
        r_bitcnt <= (w_byte_state || r_state == S_RDATA) ? r_bitcnt + 3'd1 : 3'd0;
        if (w_byte_state) r_shift <= w_byte;
        if (w_last_bit) begin
          case (r_state)
            S_ADDR: r_rw  <= r_sda_s2;
            S_PTR:  r_ptr <= w_byte[PW-1:0];
            S_WDATA: begin
              r_regs[r_ptr] <= w_byte;
              r_rx_valid    <= 1'b1;
              r_rx_addr     <= r_ptr;
              r_rx_data     <= w_byte;
              if (AUTOINC) r_ptr <= r_ptr + PTR_ONE;
            end
            S_RDATA: if (AUTOINC) r_ptr <= r_ptr + PTR_ONE;
            default: ;
          endcase
        end
      end else if (w_scl_fall) begin
        if (w_ack_state) begin
          r_sda_out <= 1'b0;
        end else if (r_state == S_RDATA) begin
          // Byte is captured at its first falling edge so local loads cannot corrupt it
          if (r_bitcnt == 3'd0) begin
            r_sda_out <= r_regs[r_ptr][7];
            r_shift   <= {r_regs[r_ptr][6:0], 1'b0};
          end else begin
            r_sda_out <= r_shift[7];
            r_shift   <= {r_shift[6:0], 1'b0};
          end
        end else begin
          r_sda_out <= 1'b1;
        end
      end
    end
  end

  assign bus.sda_out = r_sda_out;
  assign rx_valid    = r_rx_valid;
  assign rx_addr     = r_rx_addr;
  assign rx_data     = r_rx_data;
  assign busy        = w_busy;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed self-checking bench for i2c_target with an open-drain bus model

module tb_i2c_target;
  localparam int Q = 10;
  localparam int TIMEOUT = 5_000_000;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       ld_we;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic       rx_valid;
  logic [2:0] rx_addr;
  logic [7:0] rx_data;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         rx_pulses = 0;
  logic [2:0] rx_last_addr = '0;
  logic [7:0] rx_last_data = '0;

  i2c_target_if bus_if();
  assign bus_if.scl_in = m_scl;
  assign bus_if.sda_in = m_sda & bus_if.sda_out;

  i2c_target #(.DEV_ADDR(7'h52), .NUM_REGS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .rx_valid (rx_valid),
    .rx_addr  (rx_addr),
    .rx_data  (rx_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid) begin
      rx_pulses    <= rx_pulses + 1;
      rx_last_addr <= rx_addr;
      rx_last_data <= rx_data;
    end
  end

  initial begin
    #(TIMEOUT);
    errors++;
    $error("FAIL timeout waiting for test sequence to finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    s = bus_if.sda_in;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(nack, s);
  endtask

  task automatic read_reg(input logic [2:0] idx, output logic [7:0] d);
    logic a;
    i2c_start();
    write_byte(8'hA4, a);
    write_byte({5'b0, idx}, a);
    i2c_start();
    write_byte(8'hA5, a);
    read_byte(1'b1, d);
    i2c_stop();
  endtask

  task automatic ld_write(input logic [2:0] idx, input logic [7:0] val);
    ld_addr = idx;
    ld_data = val;
    ld_we   = 1'b1;
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  initial begin
    logic       a0, a1, a2, s;
    logic [7:0] d;
    logic [3:0] nib;
    int         p0;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (4) @(negedge clk);

    chk("rst_sda_out", bus_if.sda_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_addr", rx_addr, 3'd0);
    chk("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    p0 = rx_pulses;
    i2c_start();
    write_byte(8'hA4, a0);
    chk("wr_busy", busy, 1'b1);
    write_byte(8'h02, a1);
    write_byte(8'h5A, a2);
    i2c_stop();
    chk("wr_ack_addr", a0, 1'b0);
    chk("wr_ack_ptr", a1, 1'b0);
    chk("wr_ack_data", a2, 1'b0);
    chk("wr_rx_pulses", rx_pulses - p0, 1);
    chk("wr_rx_addr", rx_last_addr, 3'd2);
    chk("wr_rx_data", rx_last_data, 8'h5A);
    chk("wr_idle_busy", busy, 1'b0);
    read_reg(3'd2, d);
    chk("wr_readback", d, 8'h5A);

    ld_write(3'd3, 8'hC3);
    i2c_start();
    write_byte(8'hA4, a0);
    write_byte(8'h03, a1);
    i2c_start();
    write_byte(8'hA5, a2);
    chk("rd_ack_addr", a2, 1'b0);
    read_byte(1'b1, d);
    chk("rd_data", d, 8'hC3);
    chk("rd_release", bus_if.sda_out, 1'b1);
    chk("rd_nack_busy", busy, 1'b0);
    i2c_stop();

    p0 = rx_pulses;
    i2c_start();
    write_byte(8'hA6, a0);
    chk("mm_nack", a0, 1'b1);
    chk("mm_busy", busy, 1'b0);
    write_byte(8'h11, a1);
    write_byte(8'h11, a2);
    chk("mm_no_ack1", a1, 1'b1);
    chk("mm_no_ack2", a2, 1'b1);
    i2c_stop();
    chk("mm_rx_pulses", rx_pulses - p0, 0);

    p0 = rx_pulses;
    i2c_start();
    write_byte(8'hA4, a0);
    write_byte(8'h07, a0);
    write_byte(8'h01, a1);
    write_byte(8'h02, a2);
    i2c_stop();
    chk("ai_rx_pulses", rx_pulses - p0, 2);
    read_reg(3'd7, d);
`ifdef I2C_TARGET_AUTOINC_EN
    chk("ai_rx_addr", rx_last_addr, 3'd0);
    chk("ai_reg7", d, 8'h01);
    read_reg(3'd0, d);
    chk("ai_reg0", d, 8'h02);
`else
    chk("ai_rx_addr", rx_last_addr, 3'd7);
    chk("ai_reg7", d, 8'h02);
    read_reg(3'd0, d);
    chk("ai_reg0", d, 8'h00);
`endif

    ld_write(3'd2, 8'h00);
    read_reg(3'd2, d);
    chk("col_preclear", d, 8'h00);
    i2c_start();
    write_byte(8'hA4, a0);
    write_byte(8'h02, a0);
    for (int i = 7; i >= 1; i--) clock_bit(1'((8'h5A >> i) & 8'h01), s);
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ld_addr = 3'd2;
    ld_data = 8'hFF;
    ld_we   = 1'b1;
    @(negedge clk);
    ld_we   = 1'b0;
    chk("col_rx_valid", rx_valid, 1'b1);
    repeat (2 * Q - 3) @(negedge clk);
    m_scl = 1'b0;
    wait_q();
    clock_bit(1'b1, a1);
    chk("col_ack", a1, 1'b0);
    i2c_stop();
    read_reg(3'd2, d);
    chk("col_bus_wins", d, 8'h5A);

    i2c_start();
    write_byte(8'hA4, a0);
    write_byte(8'h03, a0);
    i2c_start();
    write_byte(8'hA5, a0);
    for (int i = 3; i >= 0; i--) begin
      clock_bit(1'b1, s);
      nib[i] = s;
    end
    chk("mr_first_nibble", nib, 4'hC);
    chk("mr_driving_low", bus_if.sda_out, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_sda_released", bus_if.sda_out, 1'b1);
    chk("mr_busy", busy, 1'b0);
    m_scl = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      chk("mr_reg_zero", d, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h52, giving the 7-bit device address it responds to.
REQ-002 The block SHALL have parameter NUM_REGS, default 8, a power of two ≥2, giving the register file depth; PW = clog2(NUM_REGS).
REQ-003 The block SHALL have the port clk, input, 1 bit, system clock.
REQ-004 The block SHALL have the port rst, input, 1 bit, reset: synchronous, active-high, sampled on clk rising edge.
REQ-005 The block SHALL have the port scl_in, input, 1 bit, bus SCL, asynchronous.
REQ-006 The block SHALL have the port sda_in, input, 1 bit, bus SDA, asynchronous.
REQ-007 The block SHALL have the port sda_out, output, 1 bit, 1 = release SDA, 0 = drive SDA low.
REQ-008 The block SHALL have the port ld_we, input, 1 bit, local register load strobe.
REQ-009 The block SHALL have the port ld_addr, input, PW bits, local load index.
REQ-010 The block SHALL have the port ld_data, input, 8 bits, local load value.
REQ-011 The block SHALL have the port rx_valid, output, 1 bit, one-cycle pulse per byte written by the bus master.
REQ-012 The block SHALL have the port rx_addr, output, PW bits, register index of the last bus write.
REQ-013 The block SHALL have the port rx_data, output, 8 bits, value of the last bus write.
REQ-014 The block SHALL have the port busy, output, 1 bit, high while addressed (any state other than IDLE or MISMATCH).

Function
REQ-015 scl_in and sda_in SHALL each pass through a 2-flop synchronizer; edge detection SHALL compare synced value with its 1-cycle-delayed copy.
REQ-016 START SHALL be detected on a synced SDA fall with synced SCL high; STOP SHALL be detected on a synced SDA rise with synced SCL high.
REQ-017 States SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, MISMATCH.
REQ-018 START in any state (repeated START included) SHALL go to ADDR with bit counter 0 and sda_out 1; STOP in any state SHALL go to IDLE with sda_out 1.
REQ-019 Data bits SHALL be sampled MSB-first on synced SCL rise; sda_out changes SHALL occur only on synced SCL fall, within 3 clk of the scl_in pin fall.
REQ-020 ADDR: after 8 bits, {addr[6:0],rw} with addr==DEV_ADDR SHALL go to ADDR_ACK, driving sda_out 0 for one SCL period; a mismatch SHALL go to MISMATCH (sda_out 1 until START/STOP).
REQ-021 After ADDR_ACK, rw=0 SHALL go to PTR; rw=1 SHALL go to RDATA, presenting reg[ptr][7] at that SCL fall.
REQ-022 PTR: the received byte's low PW bits SHALL load ptr, with ACK, then go to WDATA; upper bits SHALL be ignored.
REQ-023 WDATA: each received byte SHALL be written to reg[ptr], pulse rx_valid with rx_addr=ptr and rx_data=byte on the cycle of the 8th SCL rise, and be ACKed.
REQ-024 RDATA: 8 bits of reg[ptr] SHALL be shifted out; sda_out SHALL be 1 in RDATA_ACK, and the master's bit SHALL be sampled on SCL rise: 0 (ACK) continues with the next byte, 1 (NACK) goes to MISMATCH.
REQ-025 The ptr SHALL wrap modulo NUM_REGS.
REQ-026 ld_we SHALL write reg[ld_addr] in any state; on a same-cycle same-index collision with a bus write, the bus write SHALL win.
REQ-027 The read byte SHALL be latched into the shift register at the SCL fall that begins the byte; later ld_we updates SHALL not alter a byte in flight.

Reset
REQ-028 On rst: state IDLE, sda_out 1, rx_valid 0, rx_addr 0, rx_data 0, busy 0, ptr 0, all registers 0, synchronizer flops 1; reset mid-transfer SHALL release SDA on the next clk edge.

Configuration
REQ-029 With I2C_TARGET_AUTOINC_EN defined, ptr SHALL increment after every data byte written or read; without it, ptr SHALL stay at the value loaded in PTR.

Verification
REQ-030 START, 0xA4, 0x02, 0x5A, STOP -> ACK on all 3 bytes; rx_valid once with rx_addr=2, rx_data=0x5A; reg[2]=0x5A.
REQ-031 ld reg[3]=0xC3; START, 0xA4, 0x03, repeated START, 0xA5, read 1 byte with NACK, STOP -> bus reads 0xC3; SDA released after NACK.
REQ-032 START, 0xA6 (addr 0x53) -> no ACK (SDA high at 9th clock); following 0x11 bytes ignored, no rx_valid.
REQ-033 With AUTOINC_EN: write ptr 7, then 0x01, 0x02 -> reg[7]=0x01, reg[0]=0x02; without it: reg[7]=0x02.
REQ-034 rst asserted after 4 bits of a read byte -> sda_out=1 next cycle, busy=0, all registers read back 0.
REQ-035 Same-cycle ld_we to index 2 (0xFF) and bus write to index 2 (0x5A) -> reg[2]=0x5A.
